ddr3_bank_cmd_scheduler: RTL and testbench

- Parametrised multi-bank DDR3 command scheduler that succeeds the single-bank command state machine.
- Tracks the open row per bank and enforces per-bank tRCD/tRP/auto-precharge timers.
- Generates periodic refresh, closing all open banks first.
- Sits between the user request interface and the DDR3 pin driver, after the init/ZQ sequencer has finished.

---
 rtl/ddr3_bank_cmd_scheduler_if.sv | 25 ++
 rtl/ddr3_bank_cmd_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_ddr3_bank_cmd_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_bank_cmd_scheduler_if.sv
// Request handshake between the user front end and the DDR3 bank command scheduler.
// The scheduler drives req_ready combinationally; everything else comes from the requester.
interface ddr3_bank_cmd_scheduler_if #(
    parameter int BA_W  = 3,
    parameter int ROW_W = 15,
    parameter int COL_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic             req_ap;
    logic [BA_W-1:0]  req_bank;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;

    modport master (
        output req_valid, req_write, req_ap, req_bank, req_row, req_col,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_write, req_ap, req_bank, req_row, req_col,
        output req_ready
    );
endinterface

// File: rtl/ddr3_bank_cmd_scheduler.sv
// Multi-bank DDR3 command scheduler: per-bank open-row tracking, per-bank spacing timers
// and periodic refresh preceded by precharge-all of any open banks.
//
// state        | meaning
// S_INIT       | waiting for init/ZQ sequencer; NOP, refresh counter held at 0
// S_IDLE       | serving requests (ACT / RD / WR / PRE) or starting a refresh
// S_PREA_WAIT  | PREA issued, waiting out tRP before REF
// S_REF        | issuing REF
// S_REF_WAIT   | waiting out tRFC, then back to S_IDLE
module ddr3_bank_cmd_scheduler #(
    parameter int NUM_BANKS = 8,
    parameter int BA_W      = 3,
    parameter int ROW_W     = 15,
    parameter int COL_W     = 10,
    parameter int T_RCD     = 5,
    parameter int T_RP      = 5,
    parameter int T_AP      = 12,
    parameter int T_RFC     = 10,
    parameter int T_REFI    = 780
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     init_done,
    ddr3_bank_cmd_scheduler_if.slave req,
    output logic                     CS,
    output logic                     RAS,
    output logic                     CAS,
    output logic                     WE,
    output logic [ROW_W-1:0]         Addr_out,
    output logic [BA_W-1:0]          BA_out,
    output logic [NUM_BANKS-1:0]     bank_open,
    output logic                     ref_busy,
    output logic                     ref_late
);

    localparam logic [2:0] S_INIT      = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_PREA_WAIT = 3'd2;
    localparam logic [2:0] S_REF       = 3'd3;
    localparam logic [2:0] S_REF_WAIT  = 3'd4;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    localparam int BT_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int BT_MAX   = (BT_MAX_A > T_AP) ? BT_MAX_A : T_AP;
    localparam int BT_W     = $clog2(BT_MAX + 1);
    localparam int GT_MAX   = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int GT_W     = $clog2(GT_MAX + 1);
    localparam int RC_W     = $clog2(T_REFI + 1);

    logic [2:0]            state, state_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [ROW_W-1:0]      addr_d;
    logic [BA_W-1:0]       ba_d;
    logic [NUM_BANKS-1:0]  bank_open_d;
    logic [BT_W-1:0]       bank_timer [NUM_BANKS];
    logic [ROW_W-1:0]      open_row   [NUM_BANKS];
    logic [GT_W-1:0]       gtimer;
    logic [RC_W-1:0]       ref_cnt;
    logic                  ref_pending;

    logic                  bt_load;
    logic [BT_W-1:0]       bt_val;
    logic                  row_load;
    logic                  gt_load;
    logic [GT_W-1:0]       gt_val;
    logic                  ref_clear;
    logic                  ready;
    logic                  all_idle;
    logic                  ref_wrap;
    logic                  ref_req;
    logic                  gt_done;
    logic [BA_W-1:0]       cur_bank;

    assign cur_bank = req.req_bank;
    assign {CS, RAS, CAS, WE} = cmd_q;
    assign req.req_ready = ready;
    assign ref_busy = (state == S_PREA_WAIT) || (state == S_REF) || (state == S_REF_WAIT);

    // A wrap counts as pending in its own cycle so a simultaneous request loses to refresh.
    assign ref_wrap = (state != S_INIT) && (ref_cnt == RC_W'(T_REFI - 1));
    assign ref_req  = ref_pending || ref_wrap;

    // Leave the wait state as the timer hits 0, so the next decision lands exactly T later.
    assign gt_done  = (gtimer <= GT_W'(1));

    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_timer[i] != '0) all_idle = 1'b0;
        end
    end

    always_comb begin
        state_d     = state;
        cmd_d       = CMD_NOP;
        addr_d      = '0;
        ba_d        = '0;
        bank_open_d = bank_open;
        bt_load     = 1'b0;
        bt_val      = '0;
        row_load    = 1'b0;
        gt_load     = 1'b0;
        gt_val      = '0;
        ref_clear   = 1'b0;
        ready       = 1'b0;

        case (state)
            S_INIT: begin
                if (init_done) state_d = S_IDLE;
            end

            S_IDLE: begin
                if (ref_req) begin
                    if (all_idle) begin
                        if (bank_open != '0) begin
                            cmd_d       = CMD_PRE;
                            addr_d[10]  = 1'b1;
                            bank_open_d = '0;
                            gt_load     = 1'b1;
                            gt_val      = GT_W'(T_RP - 1);
                            state_d     = (T_RP == 1) ? S_REF : S_PREA_WAIT;
                        end else begin
                            state_d = S_REF;
                        end
                    end
                end else if (req.req_valid && (bank_timer[cur_bank] == '0)) begin
                    ba_d = cur_bank;
                    if (!bank_open[cur_bank]) begin
                        cmd_d                 = CMD_ACT;
                        addr_d                = req.req_row;
                        bank_open_d[cur_bank] = 1'b1;
                        row_load              = 1'b1;
                        bt_load               = 1'b1;
                        bt_val                = BT_W'(T_RCD - 1);
                    end else if (open_row[cur_bank] == req.req_row) begin
                        cmd_d                = req.req_write ? CMD_WR : CMD_RD;
                        addr_d[COL_W-1:0]    = req.req_col;
                        addr_d[10]           = req.req_ap;
                        addr_d[12]           = 1'b1;
                        ready                = 1'b1;
                        if (req.req_ap) begin
                            bank_open_d[cur_bank] = 1'b0;
                            bt_load               = 1'b1;
                            bt_val                = BT_W'(T_AP - 1);
                        end
                    end else begin
                        cmd_d                 = CMD_PRE;
                        bank_open_d[cur_bank] = 1'b0;
                        bt_load               = 1'b1;
                        bt_val                = BT_W'(T_RP - 1);
                    end
                end
            end

            S_PREA_WAIT: begin
                if (gt_done) state_d = S_REF;
            end

            S_REF: begin
                cmd_d     = CMD_REF;
                ref_clear = 1'b1;
                gt_load   = 1'b1;
                gt_val    = GT_W'(T_RFC - 1);
                state_d   = (T_RFC == 1) ? S_IDLE : S_REF_WAIT;
            end

            S_REF_WAIT: begin
                if (gt_done) state_d = S_IDLE;
            end

            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_INIT;
            cmd_q       <= CMD_NOP;
            Addr_out    <= '0;
            BA_out      <= '0;
            bank_open   <= '0;
            gtimer      <= '0;
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
            ref_late    <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_timer[i] <= '0;
                open_row[i]   <= '0;
            end
        end else begin
            state     <= state_d;
            cmd_q     <= cmd_d;
            Addr_out  <= addr_d;
            BA_out    <= ba_d;
            bank_open <= bank_open_d;

            for (int i = 0; i < NUM_BANKS; i++) begin
                if (bt_load && (cur_bank == BA_W'(i))) begin
                    bank_timer[i] <= bt_val;
                end else if (bank_timer[i] != '0) begin
                    bank_timer[i] <= bank_timer[i] - BT_W'(1);
                end
            end

            if (row_load) open_row[cur_bank] <= req.req_row;

            if (gt_load) begin
                gtimer <= gt_val;
            end else if (gtimer != '0) begin
                gtimer <= gtimer - GT_W'(1);
            end

            if (state == S_INIT || ref_wrap) begin
                ref_cnt <= '0;
            end else begin
                ref_cnt <= ref_cnt + RC_W'(1);
            end

            if (ref_wrap) begin
                ref_pending <= 1'b1;
            end else if (ref_clear) begin
                ref_pending <= 1'b0;
            end

            if (ref_wrap && ref_pending) ref_late <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr3_bank_cmd_scheduler.sv
// Directed bench for ddr3_bank_cmd_scheduler: one instance with default timing,
// one with a short refresh interval and long auto-precharge time for the late-refresh flag.
module tb_ddr3_bank_cmd_scheduler;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst2_n, init_done;

    logic        cs, ras, cas, we;
    logic [14:0] addr;
    logic [2:0]  ba;
    logic [7:0]  bopen;
    logic        busy, late;
    logic [3:0]  pins;

    logic        cs2, ras2, cas2, we2;
    logic [14:0] addr2;
    logic [2:0]  ba2;
    logic [7:0]  bopen2;
    logic        busy2, late2;

    assign pins = {cs, ras, cas, we};

    ddr3_bank_cmd_scheduler_if rq ();
    ddr3_bank_cmd_scheduler_if rq2 ();

    ddr3_bank_cmd_scheduler dut (
        .CLK(clk), .RESET(rst_n), .init_done(init_done), .req(rq),
        .CS(cs), .RAS(ras), .CAS(cas), .WE(we),
        .Addr_out(addr), .BA_out(ba), .bank_open(bopen),
        .ref_busy(busy), .ref_late(late)
    );

    ddr3_bank_cmd_scheduler #(
        .T_RCD(2), .T_RP(2), .T_AP(40), .T_RFC(2), .T_REFI(10)
    ) dut2 (
        .CLK(clk), .RESET(rst2_n), .init_done(init_done), .req(rq2),
        .CS(cs2), .RAS(ras2), .CAS(cas2), .WE(we2),
        .Addr_out(addr2), .BA_out(ba2), .bank_open(bopen2),
        .ref_busy(busy2), .ref_late(late2)
    );

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [2:0] b, input logic [14:0] r,
                           input logic [9:0] c, input logic w, input logic ap);
        rq.req_valid = v;
        rq.req_bank  = b;
        rq.req_row   = r;
        rq.req_col   = c;
        rq.req_write = w;
        rq.req_ap    = ap;
    endtask

    // Holds a request until accepted (bounded), then withdraws it.
    task automatic do_access(input logic [2:0] b, input logic [14:0] r, input logic [9:0] c);
        logic got;
        got = 1'b0;
        set_req(1'b1, b, r, c, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rq.req_ready) begin
                got = 1'b1;
                break;
            end
            tick(1);
        end
        chk("access_accepted", {31'd0, got}, 32'd1);
        tick(1);
        rq.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        init_done = 1'b0;
        set_req(1'b0, 3'd0, 15'd0, 10'd0, 1'b0, 1'b0);
        rq2.req_valid = 1'b0; rq2.req_write = 1'b0; rq2.req_ap = 1'b0;
        rq2.req_bank = '0; rq2.req_row = '0; rq2.req_col = '0;

        #23;
        chk("rst_pins", {28'd0, pins}, {28'd0, NOP});
        chk("rst_addr", {17'd0, addr}, 32'd0);
        chk("rst_ba", {29'd0, ba}, 32'd0);
        chk("rst_bank_open", {24'd0, bopen}, 32'd0);
        chk("rst_ready", {31'd0, rq.req_ready}, 32'd0);
        chk("rst_ref_busy", {31'd0, busy}, 32'd0);
        chk("rst_ref_late", {31'd0, late}, 32'd0);

        // Read bank2 row 0x0123 col 0x040
        init_done = 1'b1;
        set_req(1'b1, 3'd2, 15'h0123, 10'h040, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1);
        #1 chk("t1_c0_ready", {31'd0, rq.req_ready}, 32'd0);
        tick(1);
        chk("t1_act_pins", {28'd0, pins}, {28'd0, ACT});
        chk("t1_act_ba", {29'd0, ba}, 32'd2);
        chk("t1_act_addr", {17'd0, addr}, 32'h0123);
        chk("t1_bank_open", {24'd0, bopen}, 32'h04);
        #1 chk("t1_c1_ready", {31'd0, rq.req_ready}, 32'd0);
        for (int k = 2; k <= 4; k++) begin
            tick(1);
            chk("t1_gap_nop", {28'd0, pins}, {28'd0, NOP});
            #1 chk("t1_gap_ready", {31'd0, rq.req_ready}, 32'd0);
        end
        tick(1);
        #1 chk("t1_c5_ready", {31'd0, rq.req_ready}, 32'd1);
        tick(1);
        chk("t1_rd_pins", {28'd0, pins}, {28'd0, RD});
        chk("t1_rd_addr", {17'd0, addr}, 32'h1040);
        chk("t1_rd_ba", {29'd0, ba}, 32'd2);

        // Row miss on bank2: PRE, ACT, WR
        set_req(1'b1, 3'd2, 15'h0200, 10'h3FF, 1'b1, 1'b0);
        #1 chk("t2_d0_ready", {31'd0, rq.req_ready}, 32'd0);
        tick(1);
        chk("t2_pre_pins", {28'd0, pins}, {28'd0, PRE});
        chk("t2_pre_addr", {17'd0, addr}, 32'd0);
        chk("t2_pre_ba", {29'd0, ba}, 32'd2);
        chk("t2_pre_open", {24'd0, bopen}, 32'h00);
        tick(4);
        chk("t2_d5_nop", {28'd0, pins}, {28'd0, NOP});
        tick(1);
        chk("t2_act_pins", {28'd0, pins}, {28'd0, ACT});
        chk("t2_act_addr", {17'd0, addr}, 32'h0200);
        chk("t2_act_open", {24'd0, bopen}, 32'h04);
        tick(4);
        #1 chk("t2_d10_ready", {31'd0, rq.req_ready}, 32'd1);
        tick(1);
        chk("t2_wr_pins", {28'd0, pins}, {28'd0, WR});
        chk("t2_wr_addr", {17'd0, addr}, 32'h13FF);

        // WR with auto-precharge on bank0, then a stalled bank0 request
        set_req(1'b1, 3'd0, 15'h0055, 10'h008, 1'b1, 1'b1);
        tick(1);
        chk("t3_act_pins", {28'd0, pins}, {28'd0, ACT});
        chk("t3_act_ba", {29'd0, ba}, 32'd0);
        chk("t3_act_open", {24'd0, bopen}, 32'h05);
        tick(4);
        #1 chk("t3_e5_ready", {31'd0, rq.req_ready}, 32'd1);
        tick(1);
        chk("t3_wrap_pins", {28'd0, pins}, {28'd0, WR});
        chk("t3_wrap_addr", {17'd0, addr}, 32'h1408);
        chk("t3_wrap_open", {24'd0, bopen}, 32'h04);
        set_req(1'b1, 3'd0, 15'h0066, 10'h011, 1'b0, 1'b0);
        for (int k = 7; k <= 17; k++) begin
            #1 chk("t3_stall_ready", {31'd0, rq.req_ready}, 32'd0);
            tick(1);
            chk("t3_stall_nop", {28'd0, pins}, {28'd0, NOP});
        end
        tick(1);
        chk("t3_act12_pins", {28'd0, pins}, {28'd0, ACT});
        chk("t3_act12_addr", {17'd0, addr}, 32'h0066);
        chk("t3_act12_open", {24'd0, bopen}, 32'h05);
        tick(4);
        #1 chk("t3_e22_ready", {31'd0, rq.req_ready}, 32'd1);
        tick(1);
        chk("t3_rd_pins", {28'd0, pins}, {28'd0, RD});
        chk("t3_rd_addr", {17'd0, addr}, 32'h1011);
        rq.req_valid = 1'b0;

        // Open banks 1 and 5, then let the refresh interval expire
        do_access(3'd1, 15'h0A00, 10'h000);
        do_access(3'd5, 15'h0B00, 10'h001);
        chk("t4_open_before", {24'd0, bopen}, 32'h27);
        found = 1'b0;
        for (int k = 0; k < 900; k++) begin
            tick(1);
            if (pins != NOP) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_prea_seen", {31'd0, found}, 32'd1);
        chk("t4_prea_pins", {28'd0, pins}, {28'd0, PRE});
        chk("t4_prea_addr", {17'd0, addr}, 32'h0400);
        chk("t4_prea_ba", {29'd0, ba}, 32'd0);
        chk("t4_prea_open", {24'd0, bopen}, 32'h00);
        chk("t4_prea_busy", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            chk("t4_trp_nop", {28'd0, pins}, {28'd0, NOP});
            chk("t4_trp_busy", {31'd0, busy}, 32'd1);
        end
        tick(1);
        chk("t4_ref_pins", {28'd0, pins}, {28'd0, REF});
        chk("t4_ref_ba", {29'd0, ba}, 32'd0);
        chk("t4_ref_busy", {31'd0, busy}, 32'd1);
        set_req(1'b1, 3'd3, 15'h0010, 10'h005, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            #1 chk("t4_trfc_ready", {31'd0, rq.req_ready}, 32'd0);
            tick(1);
            chk("t4_trfc_nop", {28'd0, pins}, {28'd0, NOP});
            chk("t4_trfc_busy", {31'd0, busy}, 32'd1);
        end
        tick(1);
        chk("t4_ref9_nop", {28'd0, pins}, {28'd0, NOP});
        chk("t4_ref9_busy", {31'd0, busy}, 32'd0);
        tick(1);
        chk("t4_after_ref_act", {28'd0, pins}, {28'd0, ACT});
        chk("t4_after_ref_ba", {29'd0, ba}, 32'd3);
        chk("t4_after_ref_addr", {17'd0, addr}, 32'h0010);
        rq.req_valid = 1'b0;

        // Reset in the middle of the next refresh wait
        found = 1'b0;
        for (int k = 0; k < 900; k++) begin
            tick(1);
            if (pins == REF) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_ref_seen", {31'd0, found}, 32'd1);
        tick(3);
        chk("t6_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pins", {28'd0, pins}, {28'd0, NOP});
        chk("t6_rst_addr", {17'd0, addr}, 32'd0);
        chk("t6_rst_ba", {29'd0, ba}, 32'd0);
        chk("t6_rst_open", {24'd0, bopen}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_late", {31'd0, late}, 32'd0);
        set_req(1'b1, 3'd3, 15'h0777, 10'h001, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1);
        #1 chk("t6_c0_ready", {31'd0, rq.req_ready}, 32'd0);
        tick(1);
        chk("t6_first_act", {28'd0, pins}, {28'd0, ACT});
        chk("t6_first_addr", {17'd0, addr}, 32'h0777);
        chk("t6_first_open", {24'd0, bopen}, 32'h08);
        rq.req_valid = 1'b0;

        // Second instance: auto-precharge timer outlives two refresh intervals
        rq2.req_valid = 1'b1; rq2.req_bank = 3'd0; rq2.req_row = 15'h0001;
        rq2.req_col = 10'h002; rq2.req_write = 1'b1; rq2.req_ap = 1'b1;
        rst2_n = 1'b1;
        tick(1);
        chk("t5_c0_late", {31'd0, late2}, 32'd0);
        tick(2);
        #1 chk("t5_c2_ready", {31'd0, rq2.req_ready}, 32'd1);
        tick(1);
        chk("t5_wr_pins", {28'd0, cs2, ras2, cas2, we2}, {28'd0, WR});
        rq2.req_valid = 1'b0;
        tick(12);
        chk("t5_c15_late", {31'd0, late2}, 32'd0);
        chk("t5_c15_busy", {31'd0, busy2}, 32'd0);
        tick(7);
        chk("t5_c22_late", {31'd0, late2}, 32'd1);
        tick(38);
        chk("t5_c60_late", {31'd0, late2}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
